// File: rtl/spi_slave_ram_if.sv
// SPI slave front-end for the single-port RAM controller.
//
// Deserialises command frames of FW = max(AW, DW) + 2 bits (MSB first) into rx_data with a
// one-cycle rx_valid strobe. On an accepted read-data command (cmd 11) it waits up to
// TX_TIMEOUT cycles for tx_valid and then shifts tx_data out on MISO, MSB first.
//
// Ports:
//   clk, rst_n     - clock (rising edge) and asynchronous active-low reset
//   SS_n           - slave select, active-low; frames a transaction
//   MOSI           - serial command/payload input, one bit per clk
//   MISO           - serial read-data output, 0 when not shifting
//   rx_data        - last accepted frame {cmd[1:0], payload[PW-1:0]}
//   rx_valid       - one-cycle strobe qualifying rx_data
//   tx_data        - read data from the RAM
//   tx_valid       - qualifies tx_data (only observed while waiting for read data)
//   rd_pending     - read address accepted, read-data frame not yet accepted
//   err            - one-cycle protocol error pulse (bad cmd, parity, or tx timeout)
//
// Build option: define SPI_SLAVE_PARITY_EN to append a trailing odd-parity bit to each frame.
module spi_slave_ram_if #(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 8,
  parameter int unsigned TX_TIMEOUT = 15,
  localparam int unsigned PW        = (AW > DW) ? AW : DW,
  localparam int unsigned FW        = PW + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          SS_n,
  input  logic          MOSI,
  output logic          MISO,
  output logic [FW-1:0] rx_data,
  output logic          rx_valid,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          rd_pending,
  output logic          err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;
  localparam logic [2:0] WAIT_TX   = 3'd5;
  localparam logic [2:0] SHIFT_TX  = 3'd6;
  localparam logic [2:0] DONE      = 3'd7;

  // Serial frame length on the wire.
`ifdef SPI_SLAVE_PARITY_EN
  localparam int unsigned FL = FW + 1;
`else
  localparam int unsigned FL = FW;
`endif

  localparam int unsigned MAXW0 = (FW > DW) ? FW : DW;
  localparam int unsigned MAXW  = (MAXW0 > TX_TIMEOUT) ? MAXW0 : TX_TIMEOUT;
  localparam int unsigned CW    = $clog2(MAXW) + 1;

  localparam logic [CW-1:0] LAST_BIT = CW'(FL - 1);
  localparam logic [CW-1:0] TX_BITS  = CW'(DW);
  localparam logic [CW-1:0] TO_LAST  = CW'(TX_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [FL-2:0] rx_sr_q, rx_sr_d;
  logic [DW-1:0] tx_sr_q, tx_sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          miso_q, miso_d;
  logic [FW-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rd_pending_q, rd_pending_d;
  logic          err_q, err_d;

  // Frame as it stands including the bit being sampled this cycle.
  logic [FL-1:0] frame;
  logic [FW-1:0] frame_data;
  logic [1:0]    frame_cmd;
  logic          cmd_ok;
  logic          parity_ok;

  assign frame      = {rx_sr_q, MOSI};
  assign frame_data = frame[FL-1 -: FW];
  assign frame_cmd  = frame_data[FW-1 -: 2];

`ifdef SPI_SLAVE_PARITY_EN
  assign parity_ok = ^frame;
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    case (state_q)
      WRITE:     cmd_ok = ~frame_cmd[1];
      READ_ADD:  cmd_ok = (frame_cmd == 2'b10);
      READ_DATA: cmd_ok = (frame_cmd == 2'b11);
      default:   cmd_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rx_sr_d      = rx_sr_q;
    tx_sr_d      = tx_sr_q;
    cnt_d        = cnt_q;
    miso_d       = 1'b0;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rd_pending_d = rd_pending_q;
    err_d        = 1'b0;

    if (state_q != IDLE && SS_n) begin
      // Deselect aborts whatever is in flight without any strobe.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (!SS_n) state_d = CHK_CMD;
        end
        CHK_CMD: begin
          rx_sr_d = frame[FL-2:0];
          cnt_d   = CW'(1);
          if (!MOSI)             state_d = WRITE;
          else if (rd_pending_q) state_d = READ_DATA;
          else                   state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          rx_sr_d = frame[FL-2:0];
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
            if (cmd_ok && parity_ok) begin
              rx_data_d  = frame_data;
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD)  rd_pending_d = 1'b1;
              if (state_q == READ_DATA) rd_pending_d = 1'b0;
              state_d = (state_q == READ_DATA) ? WAIT_TX : DONE;
            end else begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WAIT_TX: begin
          if (tx_valid) begin
            // MSB goes out next cycle; the rest is queued pre-shifted.
            miso_d  = tx_data[DW-1];
            tx_sr_d = tx_data << 1;
            cnt_d   = CW'(1);
            state_d = SHIFT_TX;
          end else if (cnt_q == TO_LAST) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        SHIFT_TX: begin
          // cnt_q counts bits already on MISO; after DW of them MISO returns to 0.
          if (cnt_q == TX_BITS) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            miso_d  = tx_sr_q[DW-1];
            tx_sr_d = tx_sr_q << 1;
            cnt_d   = cnt_q + CW'(1);
          end
        end
        DONE: begin
          cnt_d = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rx_sr_q      <= '0;
      tx_sr_q      <= '0;
      cnt_q        <= '0;
      miso_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rd_pending_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_sr_q      <= rx_sr_d;
      tx_sr_q      <= tx_sr_d;
      cnt_q        <= cnt_d;
      miso_q       <= miso_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rd_pending_q <= rd_pending_d;
      err_q        <= err_d;
    end
  end

  assign MISO       = miso_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rd_pending = rd_pending_q;
  assign err        = err_q;

endmodule

// File: tb/tb_spi_slave_ram_if.sv
// Scoreboard bench for spi_slave_ram_if: default instance (AW=DW=8) plus a wide instance
// (AW=10, DW=16). Stimulus pushes expected strobes; monitors pop and compare on each strobe.
module tb_spi_slave_ram_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ss_n, mosi, miso;
  logic [9:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        rd_pending;
  logic        err;

  logic        w_ss_n, w_mosi, w_miso;
  logic [17:0] w_rx_data;
  logic        w_rx_valid;
  logic [15:0] w_tx_data;
  logic        w_tx_valid;
  logic        w_rd_pending;
  logic        w_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        is_err;
    logic [17:0] data;
    logic        pend;
    int          at;
  } exp_t;

  exp_t sb_q[$];
  exp_t wsb_q[$];
  exp_t mon_e;
  exp_t wmon_e;

  spi_slave_ram_if dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SS_n       (ss_n),
    .MOSI       (mosi),
    .MISO       (miso),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .rd_pending (rd_pending),
    .err        (err)
  );

  spi_slave_ram_if #(
    .AW (10),
    .DW (16)
  ) dut_w (
    .clk        (clk),
    .rst_n      (rst_n),
    .SS_n       (w_ss_n),
    .MOSI       (w_mosi),
    .MISO       (w_miso),
    .rx_data    (w_rx_data),
    .rx_valid   (w_rx_valid),
    .tx_data    (w_tx_data),
    .tx_valid   (w_tx_valid),
    .rd_pending (w_rd_pending),
    .err        (w_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic is_err, input logic [17:0] data, input logic pend, input int at);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    e.pend   = pend;
    e.at     = at;
    sb_q.push_back(e);
  endtask

  // Monitor for the default instance.
  always @(negedge clk) begin
    if (rst_n && (rx_valid || err)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe_unexpected: rx_valid=%b err=%b, required no strobe (cycle %0d)",
                 rx_valid, err, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("strobe_err", 32'(err), 32'(mon_e.is_err));
        chk("strobe_rx_valid", 32'(rx_valid), 32'(!mon_e.is_err));
        chk("rx_data", 32'(rx_data), 32'(mon_e.data));
        chk("rd_pending", 32'(rd_pending), 32'(mon_e.pend));
        if (mon_e.at >= 0) chk("strobe_cycle", 32'(cyc), 32'(mon_e.at));
      end
    end
  end

  // Monitor for the wide instance.
  always @(negedge clk) begin
    if (rst_n && (w_rx_valid || w_err)) begin
      if (wsb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w_strobe_unexpected: rx_valid=%b err=%b, required no strobe (cycle %0d)",
                 w_rx_valid, w_err, cyc);
      end else begin
        wmon_e = wsb_q.pop_front();
        chk("w_strobe_err", 32'(w_err), 32'(wmon_e.is_err));
        chk("w_rx_data", 32'(w_rx_data), 32'(wmon_e.data));
        chk("w_rd_pending", 32'(w_rd_pending), 32'(wmon_e.pend));
        if (wmon_e.at >= 0) chk("w_strobe_cycle", 32'(cyc), 32'(wmon_e.at));
      end
    end
  end

  // Drive n bits of f MSB first; returns #1 into the cycle after the last bit is sampled.
  task automatic send(input logic [17:0] f, input int n, input bit wide);
    if (wide) begin w_ss_n = 1'b0; w_mosi = 1'b0; end
    else begin ss_n = 1'b0; mosi = 1'b0; end
    @(posedge clk); #1;
    for (int i = n - 1; i >= 0; i--) begin
      if (wide) w_mosi = f[i];
      else mosi = f[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic end_frame(input bit wide);
    if (wide) w_ss_n = 1'b1;
    else ss_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Compare MISO over 9 consecutive cycles against bits[8] first.
  task automatic check_miso(input string name, input logic [8:0] bits);
    for (int k = 8; k >= 0; k--) begin
      @(negedge clk);
      chk(name, 32'(miso), 32'(bits[k]));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    w_ss_n = 1'b1; w_mosi = 1'b0; w_tx_valid = 1'b0; w_tx_data = '0;
    #1;
    chk("rst_miso", 32'(miso), 32'(0));
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    chk("rst_rd_pending", 32'(rd_pending), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_w_rx_data", 32'(w_rx_data), 32'(0));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Write address 00_5A.
    send(18'h05A, 10, 1'b0); push(1'b0, 18'h05A, 1'b0, cyc); end_frame(1'b0);

    // Read address 10_3C, then read data 11_00 with tx_valid two cycles after rx_valid.
    send(18'h23C, 10, 1'b0); push(1'b0, 18'h23C, 1'b1, cyc); end_frame(1'b0);
    send(18'h300, 10, 1'b0); push(1'b0, 18'h300, 1'b0, cyc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = 8'hA5;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check_miso("miso_a5", 9'b1010_0101_0);
    end_frame(1'b0);

    // 11_FF with nothing pending lands in READ_ADD and is rejected.
    send(18'h3FF, 10, 1'b0); push(1'b1, 18'h300, 1'b0, cyc); end_frame(1'b0);

    // tx_valid in the same cycle as rx_valid.
    send(18'h212, 10, 1'b0); push(1'b0, 18'h212, 1'b1, cyc); end_frame(1'b0);
    send(18'h334, 10, 1'b0); push(1'b0, 18'h334, 1'b0, cyc);
    tx_valid = 1'b1; tx_data = 8'h3C;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check_miso("miso_3c", 9'b0011_1100_0);
    end_frame(1'b0);

    // Timeout: no tx_valid, err 15 cycles after WAIT_TX entry; late tx_valid ignored.
    send(18'h23C, 10, 1'b0); push(1'b0, 18'h23C, 1'b1, cyc); end_frame(1'b0);
    send(18'h300, 10, 1'b0); push(1'b0, 18'h300, 1'b0, cyc); push(1'b1, 18'h300, 1'b0, cyc + 15);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); chk("miso_timeout", 32'(miso), 32'(0));
      @(posedge clk); #1;
    end
    tx_valid = 1'b1; tx_data = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("miso_late_tx", 32'(miso), 32'(0));
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    end_frame(1'b0);

    // Abort after 5 bits, then a full 01_11 frame.
    send(18'h0000D, 5, 1'b0); end_frame(1'b0);
    send(18'h111, 10, 1'b0); push(1'b0, 18'h111, 1'b0, cyc); end_frame(1'b0);

    // Asynchronous reset while shifting 0xFF out.
    send(18'h23C, 10, 1'b0); push(1'b0, 18'h23C, 1'b1, cyc); end_frame(1'b0);
    send(18'h300, 10, 1'b0); push(1'b0, 18'h300, 1'b0, cyc);
    tx_valid = 1'b1; tx_data = 8'hFF;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(posedge clk); #1;
    chk("miso_before_reset", 32'(miso), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_miso", 32'(miso), 32'(0));
    chk("arst_rx_data", 32'(rx_data), 32'(0));
    chk("arst_rd_pending", 32'(rd_pending), 32'(0));
    chk("arst_rx_valid", 32'(rx_valid), 32'(0));
    chk("arst_err", 32'(err), 32'(0));
    ss_n = 1'b1;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Wide instance: 01_BEEF.
    send(18'h1BEEF, 18, 1'b1);
    wmon_e.is_err = 1'b0; wmon_e.data = 18'h1BEEF; wmon_e.pend = 1'b0; wmon_e.at = cyc;
    wsb_q.push_back(wmon_e);
    end_frame(1'b1);
    repeat (3) @(posedge clk);
    #1;

    chk("sb_drained", 32'(sb_q.size()), 32'(0));
    chk("w_sb_drained", 32'(wsb_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_ram_if.md
# spi_slave_ram_if

Parametrised SPI slave front-end that sits between an external SPI master and the single-port RAM controller. It deserialises command frames of `2 + PW` bits and presents each frame to the RAM as one `rx_data` word with a single-cycle `rx_valid` strobe. On a read-data command it waits for `tx_valid` from the RAM, with a bounded timeout, and then serialises `tx_data` onto MISO. It also reports protocol errors and tracks whether a read address is pending.

## Interface
Parameters:
- `AW`, 8: RAM address width.
- `DW`, 8: RAM data width.
- `TX_TIMEOUT`, 15: maximum number of clk cycles to wait for `tx_valid` after a read-data frame; minimum 1.
- Derived, not overridable: `PW = max(AW, DW)` is the payload width; `FW = PW + 2` is the frame width.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `SS_n`, in, 1: slave select, active-low; frames the transaction.
- `MOSI`, in, 1: serial input, sampled once per clk, MSB first.
- `MISO`, out, 1: serial output, MSB first; 0 when not shifting.
- `rx_data`, out, `FW`: last accepted frame as `{cmd[1:0], payload[PW-1:0]}`.
- `rx_valid`, out, 1: one-cycle strobe qualifying `rx_data`.
- `tx_data`, in, `DW`: read data from the RAM.
- `tx_valid`, in, 1: qualifies `tx_data`.
- `rd_pending`, out, 1: a read address (cmd 10) has been accepted and no read-data frame (cmd 11) has been accepted since.
- `err`, out, 1: one-cycle protocol-error pulse.

## Operation
- Commands: 00 = write address, 01 = write data, 10 = read address, 11 = read data.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SHIFT_TX, DONE.
- IDLE: goes to CHK_CMD when `SS_n` is 0.
- CHK_CMD: samples `MOSI`, which is cmd[1], and shifts it in as frame bit FW-1. The next state is:
  - WRITE if the sampled bit is 0.
  - READ_DATA if the bit is 1 and `rd_pending` is 1.
  - READ_ADD if the bit is 1 and `rd_pending` is 0.
- WRITE, READ_ADD, READ_DATA: shift in the remaining FW-1 bits, one per clk. At frame completion the cmd is checked against the state:
  - WRITE accepts 00 or 01.
  - READ_ADD accepts 10.
  - READ_DATA accepts 11.
- Accepted frame: `rx_data` is loaded and `rx_valid` pulses.
  - Cmd 10 sets `rd_pending`; cmd 11 clears it.
  - WRITE and READ_ADD then go to DONE; READ_DATA goes to WAIT_TX.
- Rejected frame: `err` pulses, `rx_valid` stays 0, `rx_data` and `rd_pending` are unchanged, and the state goes to DONE.
- WAIT_TX: if `tx_valid` is 1, latch `tx_data` and go to SHIFT_TX. If `TX_TIMEOUT` cycles elapse without `tx_valid`, pulse `err` and go to DONE.
- SHIFT_TX: drive the latched data MSB first for exactly DW clk cycles, then go to DONE with `MISO` = 0.
- DONE: idle until `SS_n` is 1, then go to IDLE. Further MOSI bits are ignored.
- `SS_n` = 1 in any non-IDLE state:
  - Next state is IDLE and the bit/timeout counters clear.
  - `MISO` goes to 0 and no `rx_valid` or `err` is raised for the partial frame.
  - `rd_pending` and `rx_data` are retained.
- `tx_valid` outside WAIT_TX is ignored.
- Counters are sized `$clog2` of the largest of FW, DW and TX_TIMEOUT, plus 1.
- Asynchronous reset values: state IDLE; `MISO` 0, `rx_valid` 0, `rx_data` 0, `rd_pending` 0, `err` 0; shift registers and counters 0.
- Reset mid-operation aborts immediately with no strobes.

## Timing
- Frame: CHK_CMD samples bit FW-1; the following FW-1 cycles sample the remaining bits.
- `rx_valid` is registered: high in the cycle after the last bit is sampled, for exactly 1 cycle. `rx_data` is stable from that cycle until the next accepted frame.
- `err` is registered with the same one-cycle pulse rule.
- Read latency: with `tx_valid` sampled high in cycle T, `MISO` carries bit DW-1 during T+1 through bit 0 during T+DW. `MISO` is 0 from T+DW+1.
- `tx_valid` is sampled in WAIT_TX starting the cycle after `rx_valid`. A `tx_valid` in that very cycle is legal.
- Timeout: `err` pulses in the cycle after the TX_TIMEOUT-th consecutive WAIT_TX cycle with `tx_valid` at 0.

## Configuration
- `SPI_SLAVE_PARITY_EN` defined:
  - Each frame carries one extra trailing odd-parity bit over all FW bits, so the frame is FW+1 bits.
  - A parity mismatch pulses `err`, suppresses `rx_valid`, leaves `rd_pending` unchanged, and goes to DONE.
  - `rx_valid` moves one cycle later.
  - `rx_data` width is unchanged; the parity bit is not stored.
- Undefined: frames are FW bits with no parity checking.

## Test plan
- Defaults, write address: SS_n low, frame 00_0x5A → one `rx_valid` pulse with `rx_data` = 10'h05A; `err` 0; `rd_pending` 0.
- Read sequence: frame 10_0x3C → `rx_data` 10'h23C and `rd_pending` 1. Then frame 11_0x00 → `rx_data` 10'h300 and `rd_pending` 0; `tx_valid` with 0xA5 two cycles later → `MISO` 1,0,1,0,0,1,0,1 on consecutive cycles, then 0.
- Rejected command: frame 11_0xFF with `rd_pending` 0 (routed to READ_ADD) → `err` pulse, no `rx_valid`, `rx_data` unchanged.
- Timeout: accepted cmd-11 frame, `tx_valid` held 0 → `err` exactly 15 cycles after WAIT_TX entry; `MISO` stays 0; a later `tx_valid` is ignored.
- Abort: SS_n high after 5 frame bits, then a new full frame 01_0x11 → no strobe from the partial frame, then `rx_data` 10'h111.
- Async reset mid-SHIFT_TX → all outputs 0 immediately, without a clk edge. With AW=10, DW=16 (PW=16, FW=18), frame 01_0xBEEF → `rx_data` 18'h1BEEF.
